// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer: splits one descriptor into bounded bursts, tracks in-flight
// bursts through a size FIFO and reports completion and sticky response errors.
module dma_burst_sequencer #(
    parameter int SIZE_WIDTH      = 16,
    parameter int LEN_WIDTH       = 24,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_BURST_BYTES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_WIDTH-1:0] desc_addr,
    input  logic [LEN_WIDTH-1:0]  desc_len_bytes,
    input  logic                  desc_is_dram,
    input  logic [SIZE_WIDTH-1:0] desc_burst_bytes,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_is_dram,
    output logic [SIZE_WIDTH-1:0] req_size_bytes,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  resp_valid,
    input  logic [SIZE_WIDTH-1:0] resp_size_bytes,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            outstanding,
    output logic [LEN_WIDTH-1:0]  bytes_issued,
    output logic [LEN_WIDTH-1:0]  bytes_completed,
    output logic                  err_size,
    output logic                  err_unexpected
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [SIZE_WIDTH-1:0] MAXB = SIZE_WIDTH'(MAX_BURST_BYTES);
    localparam logic [4:0] MAXO = 5'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining, r_issued, r_completed, w_rem_n;
    logic [SIZE_WIDTH-1:0] r_burst, r_req_size, w_burst_eff, w_burst_n, w_req_size_n, w_head;
    logic [SIZE_WIDTH-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]         r_wp, r_rp;
    logic [4:0]            r_outstanding, w_out_n;
    logic                  r_is_dram, r_req_valid, r_desc_ready, r_busy, r_done;
    logic                  r_err_size, r_err_unexp;
    logic                  w_desc_acc, w_req_acc, w_pop, w_stray, w_req_valid_n;

    assign w_desc_acc  = desc_valid & r_desc_ready;
    assign w_req_acc   = r_req_valid & req_ready;
    assign w_pop       = resp_valid & (r_outstanding != '0);
    assign w_stray     = resp_valid & (r_outstanding == '0);
    assign w_head      = r_fifo[r_rp];
    assign w_burst_eff = (desc_burst_bytes == '0 || desc_burst_bytes > MAXB) ? MAXB : desc_burst_bytes;
    assign w_burst_n   = w_desc_acc ? w_burst_eff : r_burst;
    assign w_rem_n     = w_desc_acc ? desc_len_bytes :
                         w_req_acc  ? r_remaining - LEN_WIDTH'(r_req_size) : r_remaining;
    assign w_out_n     = r_outstanding + {4'd0, w_req_acc} - {4'd0, w_pop};

    always_ff @(posedge clk) begin
        r_state <= reset ? S_IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_desc_acc) w_next = desc_len_bytes != '0 ? S_ISSUE : S_DONE;
            S_ISSUE: if (w_req_acc && w_rem_n == '0) w_next = S_DRAIN;
            S_DRAIN: if (r_outstanding == '0) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request outputs are computed from next-cycle values so they can be registered.
    always_comb begin
        w_req_valid_n = w_next == S_ISSUE && w_out_n < MAXO && w_rem_n != '0;
        w_req_size_n  = w_rem_n < LEN_WIDTH'(w_burst_n) ? SIZE_WIDTH'(w_rem_n) : w_burst_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_desc_ready  <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_req_valid   <= 1'b0;
            r_req_size    <= '0;
            r_outstanding <= '0;
            r_remaining   <= '0;
            r_burst       <= '0;
            r_addr        <= '0;
            r_is_dram     <= 1'b0;
            r_issued      <= '0;
            r_completed   <= '0;
            r_err_size    <= 1'b0;
            r_err_unexp   <= 1'b0;
            r_wp          <= '0;
            r_rp          <= '0;
        end else begin
            r_desc_ready  <= w_next == S_IDLE;
            r_busy        <= w_next != S_IDLE;
            r_done        <= w_next == S_DONE;
            r_req_valid   <= w_req_valid_n;
            r_req_size    <= w_req_size_n;
            r_outstanding <= w_out_n;
            r_remaining   <= w_rem_n;
            r_burst       <= w_burst_n;
            r_addr        <= w_desc_acc ? desc_addr : w_req_acc ? r_addr + ADDR_WIDTH'(r_req_size) : r_addr;
            r_is_dram     <= w_desc_acc ? desc_is_dram : r_is_dram;
            r_issued      <= w_desc_acc ? '0 : w_req_acc ? r_issued + LEN_WIDTH'(r_req_size) : r_issued;
            r_completed   <= w_desc_acc ? '0 : w_pop ? r_completed + LEN_WIDTH'(w_head) : r_completed;
            r_err_size    <= (r_err_size & ~w_desc_acc) | (w_pop & (resp_size_bytes != w_head));
            r_err_unexp   <= (r_err_unexp & ~w_desc_acc) | w_stray;
            r_wp          <= w_req_acc ? (r_wp == LASTP ? '0 : r_wp + 1'b1) : r_wp;
            r_rp          <= w_pop ? (r_rp == LASTP ? '0 : r_rp + 1'b1) : r_rp;
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_acc) r_fifo[r_wp] <= r_req_size;
    end

    assign desc_ready      = r_desc_ready;
    assign req_valid       = r_req_valid;
    assign req_is_dram     = r_is_dram;
    assign req_size_bytes  = r_req_size;
    assign req_addr        = r_addr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign outstanding     = r_outstanding;
    assign bytes_issued    = r_issued;
    assign bytes_completed = r_completed;
    assign err_size        = r_err_size;
    assign err_unexpected  = r_err_unexp;
endmodule

// File: tb/tb_dma_burst_sequencer.sv
// tb_dma_burst_sequencer: directed checks of burst splitting, outstanding cap,
// burst defaults, zero length, error flags and reset mid-transfer.
module tb_dma_burst_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_addr = '0;
    logic [23:0] desc_len_bytes = '0;
    logic        desc_is_dram = 1'b0;
    logic [15:0] desc_burst_bytes = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_is_dram;
    logic [15:0] req_size_bytes;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [15:0] resp_size_bytes;
    logic        busy, done, err_size, err_unexpected;
    logic [4:0]  outstanding;
    logic [23:0] bytes_issued, bytes_completed;

    logic        auto_en = 1'b0, auto_valid = 1'b0;
    logic [15:0] auto_size = '0;
    logic        man_valid = 1'b0;
    logic [15:0] man_size = '0;
    logic        d0v = 1'b0, d1v = 1'b0, d2v = 1'b0;
    logic [15:0] d0s = '0, d1s = '0, d2s = '0;
    logic [15:0] sz_log [0:63];
    logic [31:0] ad_log [0:63];
    int          n_acc = 0, n_done = 0;
    int          n_chk = 0, n_err = 0;
    int          base, dbase;

    assign resp_valid      = auto_valid | man_valid;
    assign resp_size_bytes = man_valid ? man_size : auto_size;

    always #5 clk = ~clk;

    dma_burst_sequencer dut (
        .clk(clk), .reset(reset),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
        .desc_len_bytes(desc_len_bytes), .desc_is_dram(desc_is_dram), .desc_burst_bytes(desc_burst_bytes),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_dram(req_is_dram),
        .req_size_bytes(req_size_bytes), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_size_bytes(resp_size_bytes),
        .busy(busy), .done(done), .outstanding(outstanding),
        .bytes_issued(bytes_issued), .bytes_completed(bytes_completed),
        .err_size(err_size), .err_unexpected(err_unexpected)
    );

    // Mid-cycle: log requests about to be accepted, count done pulses, echo sizes 3 cycles later.
    always @(negedge clk) begin
        if (req_valid && req_ready && n_acc < 64) begin
            sz_log[n_acc] <= req_size_bytes;
            ad_log[n_acc] <= req_addr;
            n_acc <= n_acc + 1;
        end
        if (done) n_done <= n_done + 1;
        d0v <= auto_en & req_valid & req_ready;
        d0s <= req_size_bytes;
        d1v <= d0v; d1s <= d0s;
        d2v <= d1v; d2s <= d1s;
        auto_valid <= d2v;
        auto_size  <= d2s;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_desc(input logic [31:0] a, input logic [23:0] l, input logic [15:0] b, input logic d);
        desc_addr = a; desc_len_bytes = l; desc_burst_bytes = b; desc_is_dram = d;
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (done) got = 1'b1;
        end
        chk(tag, got, 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_desc_ready"}, desc_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req_valid"}, req_valid, 0);
        chk({tag, "_outstanding"}, outstanding, 0);
        chk({tag, "_issued"}, bytes_issued, 0);
        chk({tag, "_completed"}, bytes_completed, 0);
        chk({tag, "_err_size"}, err_size, 0);
        chk({tag, "_err_unexp"}, err_unexpected, 0);
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();
        chk_reset_state("rst");

        // Split: 200 bytes in 64-byte bursts from 0x1000.
        req_ready = 1'b1; auto_en = 1'b1;
        base = n_acc; dbase = n_done;
        send_desc(32'h1000, 24'd200, 16'd64, 1'b0);
        chk("split_first_valid", req_valid, 1);
        chk("split_first_size", req_size_bytes, 16'd64);
        chk("split_first_addr", req_addr, 32'h1000);
        chk("split_desc_ready", desc_ready, 0);
        wait_done("split_done");
        step();
        chk("split_nreq", n_acc - base, 4);
        chk("split_sz0", sz_log[base], 64);
        chk("split_sz3", sz_log[base+3], 8);
        chk("split_ad1", ad_log[base+1], 32'h1040);
        chk("split_ad2", ad_log[base+2], 32'h1080);
        chk("split_ad3", ad_log[base+3], 32'h10C0);
        chk("split_completed", bytes_completed, 200);
        chk("split_issued", bytes_issued, 200);
        chk("split_ndone", n_done - dbase, 1);
        chk("split_errs", {err_size, err_unexpected}, 0);
        chk("split_ready_again", desc_ready, 1);

        // Outstanding cap with responses withheld.
        auto_en = 1'b0;
        base = n_acc;
        send_desc(32'h0, 24'd1024, 16'd64, 1'b0);
        repeat (8) step();
        chk("cap_nreq", n_acc - base, 4);
        chk("cap_valid_low", req_valid, 0);
        chk("cap_outstanding", outstanding, 4);
        man_valid = 1'b1; man_size = 16'd64;
        step();
        man_valid = 1'b0;
        chk("cap_after_resp_out", outstanding, 3);
        chk("cap_after_resp_valid", req_valid, 1);
        repeat (5) step();
        chk("cap_nreq_plus1", n_acc - base, 5);
        chk("cap_outstanding2", outstanding, 4);
        chk("cap_valid_low2", req_valid, 0);
        chk("cap_err_size", err_size, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("cap_rst");

        // Burst defaults: 0 means 256, oversized clamps to 256.
        auto_en = 1'b1;
        base = n_acc;
        send_desc(32'h2000, 24'd300, 16'd0, 1'b1);
        chk("def_size0", req_size_bytes, 256);
        chk("def_is_dram", req_is_dram, 1);
        wait_done("def_done");
        chk("def_nreq", n_acc - base, 2);
        chk("def_sz1", sz_log[base+1], 44);
        chk("def_ad1", ad_log[base+1], 32'h2100);
        chk("def_completed", bytes_completed, 300);
        step();
        base = n_acc;
        send_desc(32'h3000, 24'd600, 16'd1000, 1'b0);
        chk("clamp_size0", req_size_bytes, 256);
        wait_done("clamp_done");
        chk("clamp_sz1", sz_log[base+1], 256);
        chk("clamp_sz2", sz_log[base+2], 88);
        chk("clamp_completed", bytes_completed, 600);
        step();

        // Address wraps at 2^32.
        base = n_acc;
        send_desc(32'hFFFF_FFC0, 24'd128, 16'd64, 1'b0);
        wait_done("wrap_done");
        chk("wrap_ad0", ad_log[base], 32'hFFFF_FFC0);
        chk("wrap_ad1", ad_log[base+1], 32'h0);
        chk("wrap_errs", {err_size, err_unexpected}, 0);
        step();

        // Zero length: done one cycle after accept, no request.
        base = n_acc;
        send_desc(32'h4000, 24'd0, 16'd64, 1'b0);
        chk("zero_done", done, 1);
        chk("zero_valid", req_valid, 0);
        step();
        chk("zero_done_gone", done, 0);
        chk("zero_ready", desc_ready, 1);
        chk("zero_nreq", n_acc - base, 0);

        // Error flags: wrong response size, then a stray response while idle.
        auto_en = 1'b0;
        send_desc(32'h5000, 24'd64, 16'd64, 1'b0);
        step();
        chk("err_out1", outstanding, 1);
        man_valid = 1'b1; man_size = 16'd32;
        step();
        man_valid = 1'b0;
        chk("err_size_set", err_size, 1);
        chk("err_completed_popped", bytes_completed, 64);
        chk("err_out0", outstanding, 0);
        wait_done("err_done");
        step();
        chk("err_unexp_clear", err_unexpected, 0);
        man_valid = 1'b1; man_size = 16'd16;
        step();
        man_valid = 1'b0;
        chk("err_unexp_set", err_unexpected, 1);
        chk("err_size_sticky", err_size, 1);
        send_desc(32'h0, 24'd0, 16'd0, 1'b0);
        chk("err_size_cleared", err_size, 0);
        chk("err_unexp_cleared", err_unexpected, 0);
        step();

        // Reset with two bursts in flight, then a clean 64-byte transfer.
        send_desc(32'h6000, 24'd256, 16'd64, 1'b0);
        step();
        step();
        chk("mid_out2", outstanding, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("mid_rst");
        man_valid = 1'b1; man_size = 16'd64;
        step();
        man_valid = 1'b0;
        chk("mid_stale_unexp", err_unexpected, 1);
        auto_en = 1'b1;
        base = n_acc;
        send_desc(32'h7000, 24'd64, 16'd0, 1'b0);
        chk("mid_new_size", req_size_bytes, 64);
        chk("mid_unexp_cleared", err_unexpected, 0);
        wait_done("mid_done");
        chk("mid_nreq", n_acc - base, 1);
        chk("mid_completed", bytes_completed, 64);
        chk("mid_errs", {err_size, err_unexpected}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dma_burst_sequencer.md
# dma_burst_sequencer

Upstream request generator for `memory_latency_injector`. Accepts one transfer descriptor, splits it into bursts of at most a programmed size, and issues them on the injector's `req_*` valid/ready port. It bounds in-flight bursts, matches each `resp_*` against a FIFO of issued sizes, and reports completion with a one-cycle `done` pulse plus sticky error flags.

## Interface
- `SIZE_WIDTH`, 16: burst size width; must match the injector.
- `LEN_WIDTH`, 24: descriptor length width, in bytes.
- `ADDR_WIDTH`, 32: address width.
- `MAX_OUTSTANDING`, 4: maximum issued-but-unanswered bursts; range 1..16.
- `MAX_BURST_BYTES`, 256: upper clamp on burst size; also the default when `desc_burst_bytes` is 0.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `desc_valid`  in  1  descriptor present.
- `desc_ready`  out  1  descriptor accepted when `desc_valid & desc_ready`.
- `desc_addr`  in  ADDR_WIDTH  start address.
- `desc_len_bytes`  in  LEN_WIDTH  total bytes.
- `desc_is_dram`  in  1  target select, copied to every burst.
- `desc_burst_bytes`  in  SIZE_WIDTH  burst size; 0 means `MAX_BURST_BYTES`.
- `req_valid`  out  1  burst request.
- `req_ready`  in  1  injector accepts the burst.
- `req_is_dram`  out  1  target select for the burst.
- `req_size_bytes`  out  SIZE_WIDTH  size of this burst.
- `req_addr`  out  ADDR_WIDTH  address of this burst.
- `resp_valid`  in  1  one response, one-cycle pulse.
- `resp_size_bytes`  in  SIZE_WIDTH  size of the responded burst.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `outstanding`  out  5  in-flight burst count.
- `bytes_issued`  out  LEN_WIDTH  bytes accepted by the injector for the current descriptor.
- `bytes_completed`  out  LEN_WIDTH  bytes responded for the current descriptor.
- `err_size`  out  1  sticky: a response size did not match the FIFO head.
- `err_unexpected`  out  1  sticky: a response arrived while `outstanding` was 0.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, DONE. `desc_ready` = (state==IDLE).
- **IDLE, on accept:**
  - Latch `addr`, `remaining = desc_len_bytes` and `is_dram`.
  - Effective burst = `min(desc_burst_bytes ? desc_burst_bytes : MAX_BURST_BYTES, MAX_BURST_BYTES)`.
  - Clear `bytes_issued`, `bytes_completed`, `err_size` and `err_unexpected`.
  - Next state: ISSUE if `remaining` > 0, otherwise DONE.
- **ISSUE:**
  - Drive `req_valid` when `outstanding < MAX_OUTSTANDING` and `remaining > 0`.
  - `req_size_bytes = min(remaining, burst)`.
  - Once asserted, `req_valid`, `req_size_bytes` and `req_addr` hold stable until `req_ready`.
  - On accept:
    - Push the size into the size FIFO (depth `MAX_OUTSTANDING`).
    - `addr += size`; `remaining -= size`; `bytes_issued += size`; `outstanding++`.
  - When `remaining` reaches 0, go to DRAIN.
- **DRAIN:** wait for `outstanding == 0`, then go to DONE.
- **DONE:** `done` = 1 for exactly this cycle; next state IDLE.
- **Response handling (all states):**
  - If `resp_valid` and `outstanding > 0`:
    - Pop the FIFO.
    - Set `err_size` if `resp_size_bytes` ≠ the popped value.
    - `bytes_completed += popped size`; `outstanding--`.
  - If `resp_valid` and `outstanding == 0`: set `err_unexpected`; the counters are unchanged.
- **Same-cycle accept and response:** `outstanding` is unchanged, and the FIFO push and pop both occur.
- **Arithmetic:** all additions are modulo width. `req_addr` wraps at 2^ADDR_WIDTH with no error.
- **Reset:** every state and counter clears, including during a transfer. Responses still in flight at reset arrive later and set `err_unexpected` until the next descriptor is accepted.

## Timing
- Reset values: `desc_ready` = 1; `err_size` = 0 and `err_unexpected` = 0; every other output = 0.
- All outputs are registered.
- The first `req_valid` rises 1 cycle after descriptor acceptance.
- With `req_ready` held at 1 and no outstanding limit, bursts issue back-to-back, one per cycle.
- `done` rises 1 cycle after the state enters DRAIN with `outstanding == 0`. The response that makes `outstanding` 0 leads to DRAIN→DONE on the following edge.
- Zero-length descriptor: `done` rises 1 cycle after accept, with no request issued.
- `desc_ready` returns to 1 on the cycle after `done`.

## Test plan
- **Split:** `addr` = 0x1000, `len` = 200, `burst` = 64, `req_ready` = 1, responder returns after 3 cycles.
  - Bursts are 64, 64, 64, 8 at 0x1000, 0x1040, 0x1080, 0x10C0.
  - `done` pulses once; `bytes_completed` = 200; no error flags.
- **Outstanding cap:** `len` = 1024, `burst` = 64, responses withheld.
  - Exactly 4 requests are accepted, `req_valid` then stays 0, and `outstanding` = 4.
  - Releasing one response allows exactly one more request.
- **Burst defaults:** `burst` = 0 with `len` = 300 gives bursts 256, 44. `burst` = 1000 is clamped to 256.
- **Zero length:** `len` = 0 → `done` 1 cycle after accept; `req_valid` never asserts.
- **Errors:**
  - A responder that returns size 32 for a 64-byte burst sets `err_size`.
  - A spurious `resp_valid` while IDLE sets `err_unexpected`.
  - Both flags clear on the next descriptor accept.
- **Reset mid-transfer:** assert `reset` with 2 bursts outstanding.
  - All outputs return to reset values and `desc_ready` = 1.
  - A new 64-byte descriptor then completes normally.
